ctrl_unit: RTL

CTRL_UNIT -- requirements
Module: ctrl_unit

---
 rtl/ctrl_unit_pkg.sv | 69 ++++++
 rtl/ctrl_unit_imm_gen.sv | 24 ++
 rtl/ctrl_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ctrl_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM states, opcodes,
// ALU and write-back encodings, and the registered control-strobe bundle.
package ctrl_unit_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } state_t;

    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_RET = 2'd2
    } wb_sel_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LOAD,
        CLS_STORE,
        CLS_ILLEGAL
    } ins_class_t;

    // Everything the FSM registers alongside its state; br_exec marks a branch in EXEC.
    typedef struct packed {
        logic    ir_en;
        logic    pc_en;
        logic    pc_sel;
        logic    inc_sel;
        logic    rf_we;
        logic    mem_rd;
        logic    mem_wr;
        logic    br_exec;
        wb_sel_t wb_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/ctrl_unit_imm_gen.sv
// Immediate generator: decodes the I/S/B/U/J immediate from the instruction,
// sign-extended from ins[31]; R-type and unknown opcodes give zero.
module imm_gen
    import ctrl_unit_pkg::*;
(
    input  logic [31:0] ins,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (ins[6:0])
            OP_IMM, OP_LOAD, OP_JALR: imm = {{20{ins[31]}}, ins[31:20]};
            OP_STORE:                 imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OP_BRANCH:                imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25],
                                             ins[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm = {ins[31:12], 12'b0};
            OP_JAL:                   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20],
                                             ins[30:21], 1'b0};
            default:                  imm = '0;
        endcase
    end

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer with
// registered strobes, combinational ALU-op decode and immediate generation.
module ctrl_unit
    import ctrl_unit_pkg::*;
#(
    parameter bit RESET_TRAP = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ins,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        IR_en,
    output logic        PC_en,
    output logic        PC_sel,
    output logic        INC_sel,
    output logic [31:0] imm,
    output logic [3:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic        rf_we,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        illegal
);

    state_t     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       illegal_q, illegal_d;
    ins_class_t ins_class;
    alu_op_t    alu_op_c;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;

    assign opcode   = ins[6:0];
    assign funct3   = ins[14:12];
    assign funct7_5 = ins[30];

    imm_gen u_imm_gen (
        .ins (ins),
        .imm (imm)
    );

    always_comb begin
        case (opcode)
            OP_OP, OP_IMM, OP_LUI, OP_AUIPC: ins_class = CLS_ALU;
            OP_BRANCH:                       ins_class = CLS_BRANCH;
            OP_JAL:                          ins_class = CLS_JAL;
            OP_JALR:                         ins_class = CLS_JALR;
            OP_LOAD:                         ins_class = CLS_LOAD;
            OP_STORE:                        ins_class = CLS_STORE;
            default:                         ins_class = CLS_ILLEGAL;
        endcase
    end

    // funct7[5] selects SUB only for register-register ops; for immediates it is part of imm.
    always_comb begin
        alu_op_c = ALU_ADD;
        case (opcode)
            OP_OP, OP_IMM: begin
                case (funct3)
                    3'd0:    alu_op_c = (opcode == OP_OP && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'd1:    alu_op_c = ALU_SLL;
                    3'd2:    alu_op_c = ALU_SLT;
                    3'd3:    alu_op_c = ALU_SLTU;
                    3'd4:    alu_op_c = ALU_XOR;
                    3'd5:    alu_op_c = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'd6:    alu_op_c = ALU_OR;
                    default: alu_op_c = ALU_AND;
                endcase
            end
            OP_BRANCH: alu_op_c = ALU_SUB;
            OP_LUI:    alu_op_c = ALU_PASSB;
            default:   alu_op_c = ALU_ADD;
        endcase
    end

    // Strobes are computed for the state being entered, so they come straight off flops.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
        state_d   = state_q;
        ctrl_d    = CTRL_IDLE;
        illegal_d = illegal_q;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                state_d = EXEC;
                case (ins_class)
                    CLS_ALU: begin
                        ctrl_d.rf_we = 1'b1;
                        ctrl_d.pc_en = 1'b1;
                    end
                    CLS_BRANCH: begin
                        ctrl_d.pc_en   = 1'b1;
                        ctrl_d.br_exec = 1'b1;
                    end
                    CLS_JAL, CLS_JALR: begin
                        ctrl_d.rf_we   = 1'b1;
                        ctrl_d.wb_sel  = WB_RET;
                        ctrl_d.pc_en   = 1'b1;
                        ctrl_d.inc_sel = 1'b1;
                        ctrl_d.pc_sel  = (ins_class == CLS_JALR);
                    end
                    CLS_LOAD, CLS_STORE: ctrl_d = CTRL_IDLE;
                    default: begin
                        state_d   = TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            EXEC: begin
                if (ins_class == CLS_LOAD) begin
                    state_d       = MEM;
                    ctrl_d.mem_rd = 1'b1;
                end else if (ins_class == CLS_STORE) begin
                    state_d       = MEM;
                    ctrl_d.mem_wr = 1'b1;
                end else begin
                    state_d      = FETCH;
                    ctrl_d.ir_en = 1'b1;
                end
            end
            MEM: begin
                if (!mem_ready) begin
                    ctrl_d.mem_rd = ctrl_q.mem_rd;
                    ctrl_d.mem_wr = ctrl_q.mem_wr;
                end else if (ctrl_q.mem_rd) begin
                    state_d       = WB;
                    ctrl_d.rf_we  = 1'b1;
                    ctrl_d.wb_sel = WB_MEM;
                    ctrl_d.pc_en  = 1'b1;
                end else begin
                    state_d      = FETCH;
                    ctrl_d.ir_en = 1'b1;
                end
            end
            WB: begin
                state_d      = FETCH;
                ctrl_d.ir_en = 1'b1;
            end
            TRAP: begin
                if (!RESET_TRAP) begin
                    state_d      = FETCH;
                    ctrl_d.ir_en = 1'b1;
                end
            end
            default: begin
                state_d      = FETCH;
                ctrl_d.ir_en = 1'b1;
            end
        endcase
    end

    // Reset lands in FETCH with ir_en already set so the first cycle out of reset loads IR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            ctrl_q       <= CTRL_IDLE;
            ctrl_q.ir_en <= 1'b1;
            illegal_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    // NOTE: rst_n is itself synchronous, so gating strobes with it is glitch-free and keeps them low while reset is held.
    assign IR_en   = ctrl_q.ir_en & rst_n;
    assign rf_we   = ctrl_q.rf_we & rst_n;
    assign mem_rd  = ctrl_q.mem_rd & rst_n;
    assign mem_wr  = ctrl_q.mem_wr & rst_n;
    // A store retires on the mem_ready cycle itself, so its PC step follows the completion strobe.
    assign PC_en   = (ctrl_q.pc_en | (ctrl_q.mem_wr & mem_ready)) & rst_n;
    assign PC_sel  = ctrl_q.pc_sel;
    assign INC_sel = ctrl_q.inc_sel | (ctrl_q.br_exec & br_taken);
    assign wb_sel  = ctrl_q.wb_sel;
    assign alu_op  = alu_op_c;
    assign illegal = illegal_q;

endmodule
